cdb_arbiter: RTL and testbench

- Round-robin arbiter that shares the single common data bus (CDB) among NUM_REQ functional-unit result ports (ALU, MUL/DIV, FPU, LSU).
- Grants at most one result per cycle and drives registered cdb_valid/cdb_tag/cdb_value. Reservation stations and the ROB snoop these outputs.
- Losing requesters hold their result until granted. Ungranted results are never dropped, except on flush.

---
 rtl/cdb_arbiter_pkg.sv | 13 +
 rtl/cdb_arbiter_rr_priority_picker.sv | 29 ++
 rtl/cdb_arbiter.sv | 56 +++++
 tb/tb_cdb_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: widths, FU indices and helpers shared by the out-of-order blocks
package cdb_arbiter_pkg;
   localparam int CDB_TAG_WIDTH  = 3;
   localparam int CDB_DATA_WIDTH = 32;
   localparam int CDB_NUM_FU     = 4;
   localparam int FU_ALU = 0;
   localparam int FU_MUL = 1;
   localparam int FU_FPU = 2;
   localparam int FU_LSU = 3;
   function automatic int rr_wrap(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction
endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// cdb_arbiter_rr_priority_picker: first set request at or after ptr, wrapping; one-hot grant plus index
module cdb_arbiter_rr_priority_picker
   import cdb_arbiter_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = rr_wrap(int'(ptr), k, N);
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the common data bus among FU result ports.
// Grant is combinational from req_valid/rr_ptr/flush; the broadcast is registered.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = CDB_NUM_FU,
   parameter int DATA_WIDTH = CDB_DATA_WIDTH,
   parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
   localparam int IW        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          flush,
   output logic                          cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag,
   output logic [DATA_WIDTH-1:0]         cdb_value,
   output logic [IW-1:0]                 cdb_src
);
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] eligible;
   // Flush and reset hide every request, so nothing is granted in those cycles.
   assign eligible = (flush || !rst_n) ? '0 : req_valid;
   cdb_arbiter_rr_priority_picker #(.N(NUM_REQ)) picker (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (req_ready),
      .idx   (pick_idx),
      .any   (pick_any)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else if (flush) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
      end else if (pick_any) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= req_tag[int'(pick_idx)*TAG_WIDTH +: TAG_WIDTH];
         cdb_value <= req_value[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
         cdb_src   <= pick_idx;
         rr_ptr    <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + IW'(1);
      end else begin
         cdb_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus randomized traffic checked against a queue-level model of pending FU results
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int TW = 3;
   localparam int DW = 32;
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_value;
   logic [N-1:0]    req_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_value;
   logic [1:0]      cdb_src;
   cdb_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_value (req_value),
      .req_ready (req_ready),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
   );
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   bit            pend[N];
   logic [TW-1:0] ptag[N];
   logic [DW-1:0] pval[N];
   int            mptr = 0;
   bit            ev = 1'b0;
   logic [TW-1:0] et = '0;
   logic [DW-1:0] evl = '0;
   int            es = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic post(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
      pend[i] = 1'b1;
      ptag[i] = t;
      pval[i] = v;
   endtask
   task automatic refill(input int pct);
      for (int i = 0; i < N; i++)
         if (!pend[i] && $urandom_range(99) < pct) post(i, TW'($urandom), $urandom);
   endtask
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = pend[i];
         req_tag[i*TW +: TW]  = ptag[i];
         req_value[i*DW +: DW] = pval[i];
      end
   endtask
   function automatic int pick();
      for (int k = 0; k < N; k++)
         if (pend[(mptr + k) % N]) return (mptr + k) % N;
      return -1;
   endfunction
   task automatic model_reset();
      ev = 1'b0;
      mptr = 0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
   endtask
   // Starts just after a rising edge; drives, checks the grant, then checks the broadcast after the edge.
   task automatic step(input bit fl);
      int g;
      flush = fl;
      drive();
      #1;
      g = fl ? -1 : pick();
      check("req_ready", 64'(req_ready), g < 0 ? 64'd0 : (64'd1 << g));
      if (fl) model_reset();
      else if (g >= 0) begin
         ev = 1'b1;
         et = ptag[g];
         evl = pval[g];
         es = g;
         mptr = (g + 1) % N;
         pend[g] = 1'b0;
      end else ev = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("cdb_valid", 64'(cdb_valid), 64'(ev));
      if (ev) begin
         check("cdb_tag", 64'(cdb_tag), 64'(et));
         check("cdb_value", 64'(cdb_value), 64'(evl));
         check("cdb_src", 64'(cdb_src), 64'(es));
      end
      check("rr_ptr", 64'(dut.rr_ptr), 64'(mptr));
   endtask
   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         ptag[i] = '0;
         pval[i] = '0;
      end
      for (int i = 0; i < N; i++) post(i, TW'(i + 1), 32'h1000 + i);
      drive();
      #12;
      check("reset req_ready", 64'(req_ready), 64'd0);
      check("reset cdb_valid", 64'(cdb_valid), 64'd0);
      check("reset rr_ptr", 64'(dut.rr_ptr), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0);
      check("first src", 64'(cdb_src), 64'd0);
      repeat (8) begin
         refill(100);
         step(1'b0);
      end
      step(1'b1);
      post(2, 3'd5, 32'hDEADBEEF);
      step(1'b0);
      check("single tag", 64'(cdb_tag), 64'd5);
      check("single ptr", 64'(dut.rr_ptr), 64'd3);
      post(1, 3'd2, 32'h1111);
      post(3, 3'd4, 32'h3333);
      step(1'b0);
      check("wrap first", 64'(cdb_src), 64'd3);
      step(1'b0);
      check("wrap second", 64'(cdb_src), 64'd1);
      check("wrap ptr", 64'(dut.rr_ptr), 64'd2);
      post(0, 3'd7, 32'h7777);
      step(1'b1);
      post(1, 3'd1, 32'hAAAA);
      post(2, 3'd6, 32'hBBBB);
      step(1'b0);
      step(1'b0);
      check("held tag", 64'(cdb_tag), 64'd6);
      repeat (3000) begin
         refill(40);
         step($urandom_range(15) == 0);
      end
      post(0, 3'd3, 32'hCAFE);
      post(1, 3'd2, 32'hF00D);
      step(1'b0);
      check("pre-reset valid", 64'(cdb_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async reset valid", 64'(cdb_valid), 64'd0);
      check("async reset ptr", 64'(dut.rr_ptr), 64'd0);
      model_reset();
      drive();
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (20) begin
         refill(60);
         step(1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
